pulse_sync_src: RTL and testbench

PULSE_SYNC_SRC -- requirements
Module: pulse_sync_src

---
 rtl/pulse_sync_pkg.sv | 17 +
 rtl/pulse_sync_src.sv | 92 +++++++++
 tb/tb_pulse_sync_src.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared types and sizing helpers for the pulse synchronizer source side.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStrobe = 2'd1,
    StGuard  = 2'd2
  } state_e;

  // Bits needed to hold the larger of the two counter load values plus one.
  function automatic int unsigned cnt_width(input int hold, input int guard);
    int m;
    m = (hold > guard) ? hold : guard;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_sync_src.sv
// Source half of a level-strobe pulse synchronizer: captures one word, raises stb for
// HOLD_CYCLES enabled cycles, then keeps data_out stable for GUARD_CYCLES more.
module pulse_sync_src
  import pulse_sync_pkg::*;
#(
  parameter int N            = 8,
  parameter int HOLD_CYCLES  = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [N-1:0] data_out,
  output logic         stb,
  output logic         busy
);

  if (HOLD_CYCLES < 1 || GUARD_CYCLES < 0) begin : g_param_check
    $error("pulse_sync_src: HOLD_CYCLES must be >= 1 and GUARD_CYCLES >= 0");
  end

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, GUARD_CYCLES);
  localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GuardLoad = (GUARD_CYCLES > 0) ? CntW'(GUARD_CYCLES - 1) : '0;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    data_q, data_d;
  logic            stb_q, stb_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (ena) begin
      case (state_q)
        StIdle: begin
          if (valid_in) begin
            state_d = StStrobe;
            cnt_d   = HoldLoad;
            data_d  = data_in;
          end
        end
        StStrobe: begin
          if (cnt_q == '0) begin
            if (GUARD_CYCLES == 0) begin
              state_d = StIdle;
            end else begin
              state_d = StGuard;
              cnt_d   = GuardLoad;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StGuard: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // stb is registered from the next state so it never glitches across domains.
    stb_d = (state_d == StStrobe);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
    end
  end

  assign ready_out = (state_q == StIdle) && ena;
  assign busy      = (state_q != StIdle);
  assign stb       = stb_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_pulse_sync_src.sv
// Bench for pulse_sync_src: a default instance and a HOLD=1/GUARD=0 instance share stimulus.
module tb_pulse_sync_src;

  localparam int H0 = 4;
  localparam int G0 = 2;
  localparam int H1 = 1;
  localparam int G1 = 0;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       valid_in;
  logic [7:0] data_in;

  logic       r0, s0, b0;
  logic [7:0] d0;
  logic       r1, s1, b1;
  logic [7:0] d1;

  int n_checks;
  int n_errors;

  // Reference model: enabled cycles of busy time remaining after the last acceptance.
  int         left0, left1;
  logic [7:0] word0, word1;

  pulse_sync_src #(.N(8), .HOLD_CYCLES(H0), .GUARD_CYCLES(G0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(r0),
    .data_out (d0),
    .stb      (s0),
    .busy     (b0)
  );

  pulse_sync_src #(.N(8), .HOLD_CYCLES(H1), .GUARD_CYCLES(G1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(r1),
    .data_out (d1),
    .stb      (s1),
    .busy     (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    left0 = 0;
    left1 = 0;
    word0 = '0;
    word1 = '0;
  endtask

  // Drive one cycle of inputs, step the model at the edge, return 1 ns after it.
  task automatic cycle(input logic e, input logic v, input logic [7:0] d);
    ena      = e;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    if (!rst && e) begin
      if (left0 == 0) begin
        if (v) begin
          left0 = H0 + G0;
          word0 = d;
        end
      end else begin
        left0--;
      end
      if (left1 == 0) begin
        if (v) begin
          left1 = H1 + G1;
          word1 = d;
        end
      end else begin
        left1--;
      end
    end
    #1;
  endtask

  task automatic flush();
    repeat (9) cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    cycle(1'b1, 1'b1, 8'h3C);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (r0 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: got %b, required 1", r0);
    end
    cycle(1'b1, 1'b1, 8'h3C);
    n_checks++;
    if (s0 !== 1'b1 || d0 !== 8'h3C) begin
      n_errors++;
      $display("FAIL first_accept: got stb=%b data=%h, required stb=1 data=3c", s0, d0);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (s0 !== 1'b0 || d0 !== 8'h00 || b0 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: got stb=%b data=%h busy=%b, required 0/00/0", s0, d0, b0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (r0 !== 1'b1 || s0 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got ready=%b stb=%b, required ready=1 stb=0", r0, s0);
    end
  endtask

  task automatic test_single();
    int stb_count;
    flush();
    cycle(1'b1, 1'b1, 8'hA5);
    stb_count = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) cycle(1'b1, 1'b1, 8'($urandom));
      if (s0 === 1'b1) stb_count++;
      n_checks++;
      if (s0 !== (k <= H0) || b0 !== (k <= H0 + G0) || r0 !== (k == 7) || d0 !== 8'hA5) begin
        n_errors++;
        $display("FAIL single_k%0d: got stb=%b busy=%b ready=%b data=%h, required %b/%b/%b/a5",
                 k, s0, b0, r0, d0, k <= H0, k <= H0 + G0, k == 7);
      end
    end
    n_checks++;
    if (stb_count != H0) begin
      n_errors++;
      $display("FAIL single_stb_len: got %0d, required %0d", stb_count, H0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] last;
    flush();
    last = '0;
    for (int c = 0; c < 28; c++) begin
      d = 8'($urandom);
      cycle(1'b1, 1'b1, d);
      if (c % 7 == 0) last = d;
      n_checks++;
      if (d0 !== last || s0 !== (c % 7 < H0) || r0 !== (c % 7 == 6)) begin
        n_errors++;
        $display("FAIL b2b_c%0d: got data=%h stb=%b ready=%b, required %h/%b/%b",
                 c, d0, s0, r0, last, c % 7 < H0, c % 7 == 6);
      end
    end
  endtask

  task automatic test_ena_freeze();
    int stb_count;
    flush();
    stb_count = 0;
    cycle(1'b1, 1'b1, 8'h5A);
    if (s0 === 1'b1) stb_count++;
    cycle(1'b1, 1'b0, 8'h00);
    if (s0 === 1'b1) stb_count++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'($urandom));
      if (s0 === 1'b1) stb_count++;
      n_checks++;
      if (r0 !== 1'b0 || s0 !== 1'b1 || d0 !== 8'h5A) begin
        n_errors++;
        $display("FAIL freeze_i%0d: got ready=%b stb=%b data=%h, required 0/1/5a", i, r0, s0, d0);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'($urandom));
      if (s0 === 1'b1) stb_count++;
    end
    n_checks++;
    if (stb_count != 7 || d0 !== 8'h5A) begin
      n_errors++;
      $display("FAIL freeze_total: got stb cycles=%0d data=%h, required 7/5a", stb_count, d0);
    end
  endtask

  task automatic test_rst_mid();
    flush();
    cycle(1'b1, 1'b1, 8'hC3);
    cycle(1'b1, 1'b0, 8'h00);
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (s0 !== 1'b0 || b0 !== 1'b0 || d0 !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_mid_abort: got stb=%b busy=%b data=%h, required 0/0/00", s0, b0, d0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'($urandom));
      n_checks++;
      if (s0 !== 1'b0 || b0 !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_mid_quiet_i%0d: got stb=%b busy=%b, required 0/0", i, s0, b0);
      end
    end
  endtask

  task automatic test_zero_guard();
    logic [7:0] d;
    logic [7:0] last;
    flush();
    last = d1;
    for (int c = 0; c < 12; c++) begin
      d = 8'($urandom);
      cycle(1'b1, 1'b1, d);
      if (c % 2 == 0) last = d;
      n_checks++;
      if (s1 !== (c % 2 == 0) || d1 !== last || b1 !== (c % 2 == 0)) begin
        n_errors++;
        $display("FAIL zero_guard_c%0d: got stb=%b data=%h busy=%b, required %b/%h/%b",
                 c, s1, d1, b1, c % 2 == 0, last, c % 2 == 0);
      end
    end
  endtask

  task automatic test_random();
    logic e;
    for (int c = 0; c < 400; c++) begin
      e = ($urandom_range(0, 3) != 0);
      cycle(e, 1'($urandom), 8'($urandom));
      n_checks++;
      if (s0 !== (left0 > G0) || b0 !== (left0 > 0) || d0 !== word0 ||
          r0 !== (left0 == 0 && e)) begin
        n_errors++;
        $display("FAIL random0_c%0d: got stb=%b busy=%b data=%h ready=%b, required %b/%b/%h/%b",
                 c, s0, b0, d0, r0, left0 > G0, left0 > 0, word0, left0 == 0 && e);
      end
      n_checks++;
      if (s1 !== (left1 > G1) || b1 !== (left1 > 0) || d1 !== word1 ||
          r1 !== (left1 == 0 && e)) begin
        n_errors++;
        $display("FAIL random1_c%0d: got stb=%b busy=%b data=%h ready=%b, required %b/%b/%h/%b",
                 c, s1, b1, d1, r1, left1 > G1, left1 > 0, word1, left1 == 0 && e);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    ena      = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_ena_freeze();
    test_rst_mid();
    test_zero_guard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
